// File: rtl/display_wavecapture.sv
// Multi-channel circular waveform capture with pre/post-trigger control.
// Acquisition fills a block-RAM ring; display reads trigger-aligned samples.
module display_wavecapture #(
  parameter int N_CH  = 2,
  parameter int BW    = 14,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic [AW-1:0]    pretrig_len,
  input  logic             sample_valid,
  input  logic [N_CH*BW-1:0] sample_data,
  input  logic             trig,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  input  logic [CW-1:0]    rd_ch,
  output logic [BW-1:0]    rd_data,
  output logic             rd_valid,
  output logic [2:0]       state,
  output logic             done,
  output logic [AW-1:0]    trig_addr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   pre_cnt_q, pre_cnt_d;
  logic [AW-1:0]   post_cnt_q, post_cnt_d;
  logic [AW-1:0]   plen_q, plen_d;
  logic [AW-1:0]   trig_addr_q, trig_addr_d;
  logic [AW-1:0]   post_len;
  logic [AW-1:0]   rd_phys;
  logic            we;
  logic            capturing;
  logic [BW-1:0]   rd_data_q;
  logic            rd_valid_q;

  logic [N_CH*BW-1:0] mem [DEPTH];

  function automatic logic [BW-1:0] pick(
    input logic [N_CH*BW-1:0] w,
    input logic [CW-1:0]      ch
  );
    logic [BW-1:0] r;
    r = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (int'(ch) == c) r = w[c*BW +: BW];
    end
    return r;
  endfunction

  assign capturing = (state_q == S_PRE) ||
                     (state_q == S_ARMED) ||
                     (state_q == S_POST);
  assign post_len = LAST - plen_q;
  assign rd_phys  = trig_addr_q - plen_q + rd_addr;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    plen_d      = plen_q;
    trig_addr_d = trig_addr_q;
    we          = 1'b0;
    // A new arm restarts the capture and drops any sample this cycle
    if (arm) begin
      wr_ptr_d  = '0;
      pre_cnt_d = '0;
      plen_d    = pretrig_len;
      state_d   = (pretrig_len == '0) ? S_ARMED : S_PRE;
    end else if (sample_valid && capturing) begin
      we       = 1'b1;
      wr_ptr_d = wr_ptr_q + AW'(1);
      unique case (state_q)
        S_PRE: begin
          pre_cnt_d = pre_cnt_q + AW'(1);
          if (pre_cnt_q == plen_q - AW'(1)) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (trig) begin
            trig_addr_d = wr_ptr_q;
            post_cnt_d  = post_len;
            state_d     = (post_len == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          post_cnt_d = post_cnt_q - AW'(1);
          if (post_cnt_q == AW'(1)) state_d = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      plen_q      <= '0;
      trig_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      plen_q      <= plen_d;
      trig_addr_q <= trig_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= sample_data;
  end

  // Read-before-write: a same-address write lands after this read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= pick(mem[rd_phys], rd_ch);
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign state     = state_q;
  assign done      = (state_q == S_DONE);
  assign trig_addr = trig_addr_q;

endmodule

// File: tb/tb_display_wavecapture.sv
// Bench for display_wavecapture: directed capture scenarios plus random
// traffic, checked every cycle against a record-level behavioural model.
module tb_display_wavecapture;
  localparam int N_CH  = 2;
  localparam int BW    = 14;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm;
  logic [AW-1:0] pretrig_len;
  logic          sample_valid;
  logic [N_CH*BW-1:0] sample_data;
  logic          trig;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_ch;
  logic [BW-1:0] rd_data;
  logic          rd_valid;
  logic [2:0]    state;
  logic          done;
  logic [AW-1:0] trig_addr;

  display_wavecapture #(.N_CH(N_CH), .BW(BW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .arm(arm), .pretrig_len(pretrig_len),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .trig(trig), .rd_en(rd_en), .rd_addr(rd_addr), .rd_ch(rd_ch),
    .rd_data(rd_data), .rd_valid(rd_valid), .state(state),
    .done(done), .trig_addr(trig_addr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Record model: samples written since arm and index of the trigger sample
  bit   m_active;
  int   m_plen, m_n, m_tidx, m_taddr;
  logic [BW-1:0] m_ram [DEPTH][N_CH];
  bit   m_wr [DEPTH];
  bit   m_rv, m_known;
  int   m_rdat;
  bit   cmp_on = 1'b0;

  function automatic int mstate();
    if (!m_active) return 0;
    if (m_n < m_plen) return 1;
    if (m_tidx < 0) return 2;
    if (m_n - 1 - m_tidx >= DEPTH - 1 - m_plen) return 4;
    return 3;
  endfunction

  always @(posedge clk) begin
    int st, a;
    if (rst) begin
      m_active = 0; m_plen = 0; m_n = 0; m_tidx = -1;
      m_taddr = 0; m_rv = 0; m_rdat = 0; m_known = 1;
    end else begin
      m_rv = rd_en;
      if (rd_en) begin
        a = (m_taddr - m_plen + int'(rd_addr)) & (DEPTH - 1);
        m_known = m_wr[a];
        if (m_wr[a]) m_rdat = int'(m_ram[a][rd_ch]);
      end
      st = mstate();
      if (arm) begin
        m_active = 1; m_plen = int'(pretrig_len);
        m_n = 0; m_tidx = -1;
      end else if (sample_valid && st >= 1 && st <= 3) begin
        a = m_n % DEPTH;
        m_ram[a][0] = sample_data[BW-1:0];
        m_ram[a][1] = sample_data[2*BW-1:BW];
        m_wr[a] = 1;
        if (st == 2 && trig) begin
          m_tidx = m_n; m_taddr = a;
        end
        m_n++;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("state", int'(state), mstate());
      chk("done", int'(done), int'(mstate() == 4));
      chk("trig_addr", int'(trig_addr), m_taddr);
      chk("rd_valid", int'(rd_valid), int'(m_rv));
      if (m_known) chk("rd_data", int'(rd_data), m_rdat);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_arm(int p);
    arm = 1; pretrig_len = AW'(p);
    sample_valid = 1; sample_data = '1;
    tick();
    arm = 0; sample_valid = 0;
  endtask

  task automatic smp(int v, bit t);
    sample_valid = 1; trig = t;
    sample_data = {BW'(100 + v), BW'(v)};
    tick();
    sample_valid = 0; trig = 0;
  endtask

  task automatic rdchk(string nm, int a, int ch, int exp);
    rd_en = 1; rd_addr = AW'(a); rd_ch = 1'(ch);
    tick();
    rd_en = 0;
    chk(nm, int'(rd_data), exp);
  endtask

  initial begin
    rst = 1; arm = 0; pretrig_len = '0; sample_valid = 0;
    sample_data = '0; trig = 0; rd_en = 0; rd_addr = '0; rd_ch = 0;
    tick(); tick();
    cmp_on = 1;
    chk("rst_state", int'(state), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rdv", int'(rd_valid), 0);
    chk("rst_rdd", int'(rd_data), 0);
    chk("rst_taddr", int'(trig_addr), 0);
    rst = 0;
    tick();

    do_arm(4);
    for (int i = 0; i <= 20; i++) begin
      smp(i, i == 9);
      if (i == 19) chk("s1_notdone", int'(done), 0);
    end
    chk("s1_done", int'(done), 1);
    chk("s1_taddr", int'(trig_addr), 9);
    for (int k = 0; k < DEPTH; k++) begin
      rdchk("s1_ch0", k, 0, 5 + k);
      rdchk("s1_ch1", k, 1, 105 + k);
    end

    do_arm(4);
    chk("s2_pre", int'(state), 1);
    for (int i = 0; i <= 17; i++) begin
      smp(i, i == 2 || i == 6);
      if (i == 16) chk("s2_notdone", int'(done), 0);
    end
    chk("s2_done", int'(done), 1);
    rdchk("s2_trig", 4, 0, 6);

    do_arm(0);
    chk("s3_armed", int'(state), 2);
    smp(50, 1);
    chk("s3_post", int'(state), 3);
    chk("s3_taddr", int'(trig_addr), 0);
    rdchk("s3_rd0", 0, 0, 50);

    do_arm(15);
    for (int i = 0; i < 15; i++) smp(i, 0);
    chk("s4_armed", int'(state), 2);
    smp(77, 1);
    chk("s4_done", int'(state), 4);
    chk("s4_taddr", int'(trig_addr), 15);
    rdchk("s4_trig", 15, 0, 77);
    rdchk("s4_old", 0, 0, 0);

    do_arm(2);
    for (int i = 0; i < 40; i++) smp(i, i == 39);
    chk("s5_taddr", int'(trig_addr), 7);
    for (int i = 40; i <= 52; i++) smp(i, 0);
    chk("s5_done", int'(done), 1);
    rdchk("s5_trig", 2, 0, 39);
    rdchk("s5_old", 0, 0, 37);
    rdchk("s5_new", 15, 1, 152);

    rd_en = 1; rd_addr = '0; tick(); rd_en = 0;
    chk("pulse_hi", int'(rd_valid), 1);
    tick();
    chk("pulse_lo", int'(rd_valid), 0);

    do_arm(4);
    for (int i = 0; i < 5; i++) smp(i, i == 4);
    chk("s6_post", int'(state), 3);
    rd_en = 1; tick(); rd_en = 0;
    rst = 1; #1;
    chk("s6_rst_state", int'(state), 0);
    chk("s6_rst_done", int'(done), 0);
    chk("s6_rst_rdv", int'(rd_valid), 0);
    tick(); rst = 0; tick();

    do_arm(4);
    for (int i = 0; i < 5; i++) smp(i, i == 4);
    chk("s7_post", int'(state), 3);
    do_arm(3);
    chk("s7_pre", int'(state), 1);
    for (int i = 0; i < 3; i++) smp(i, 1);
    chk("s7_armed", int'(state), 2);
    smp(9, 0);
    chk("s7_still", int'(state), 2);

    for (int c = 0; c < 4000; c++) begin
      arm = ($urandom % 60) == 0;
      pretrig_len = AW'($urandom);
      sample_valid = ($urandom % 10) < 7;
      sample_data = 28'($urandom);
      trig = ($urandom % 16) == 0;
      rd_en = $urandom % 2;
      rd_addr = AW'($urandom);
      rd_ch = 1'($urandom);
      rst = ($urandom % 400) == 0;
      tick();
    end
    rst = 0; arm = 0; sample_valid = 0; trig = 0; rd_en = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
